// File: rtl/captura_operandos_n.sv
// rtl/captura_operandos_n.sv - hex keypad operand capture with backspace, early close and handshake re-arm
module captura_operandos_n #(
   parameter int NUM_OPS = 2,
   parameter int DIGITS  = 2,
   localparam int W  = 4 * DIGITS,
   localparam int IW = $clog2(NUM_OPS),
   localparam int NW = $clog2(DIGITS + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [3:0]           tecla,
   input  logic                 tecla_valida,
   input  logic                 tecla_borrar,
   input  logic                 tecla_enter,
   input  logic                 consumido,
   output logic [NUM_OPS*W-1:0] operandos,
   output logic [IW-1:0]        op_idx,
   output logic [NW-1:0]        num_digitos,
   output logic                 ready_operands
);

   typedef enum logic {
      S_CAPTURA = 1'b0,
      S_READY   = 1'b1
   } state_t;

   localparam logic [IW-1:0] LAST_OP  = IW'(NUM_OPS - 1);
   localparam logic [NW-1:0] LAST_DIG = NW'(DIGITS - 1);

   state_t               state_q, state_d;
   logic [NUM_OPS*W-1:0] ops_q, ops_d;
   logic [IW-1:0]        op_idx_q, op_idx_d;
   logic [NW-1:0]        num_q, num_d;
   logic                 ready_q, ready_d;

   logic [31:0]          base;
   logic [W-1:0]         cur;
   logic [W+3:0]         shl_ext;
   logic [W+3:0]         shr_ext;
   logic [W-1:0]         cur_d;
   logic                 wr_cur;
   logic                 close_op;

   // Locate the operand being edited and precompute its shifted variants.
   always_comb begin
      base    = 32'(op_idx_q) * 32'(W);
      cur     = ops_q[base +: W];
      shl_ext = {cur, tecla};
      shr_ext = {4'b0000, cur};
   end

   // Next-state: strobe priority borrar > enter > valida; a closing edge advances immediately.
   always_comb begin
      state_d  = state_q;
      ops_d    = ops_q;
      op_idx_d = op_idx_q;
      num_d    = num_q;
      ready_d  = ready_q;
      cur_d    = cur;
      wr_cur   = 1'b0;
      close_op = 1'b0;
      case (state_q)
         S_CAPTURA: begin
            if (tecla_borrar) begin
               if (num_q != '0) begin
                  cur_d  = shr_ext[W+3:4];
                  wr_cur = 1'b1;
                  num_d  = num_q - 1'b1;
               end
            end else if (tecla_enter) begin
               if (num_q != '0) begin
                  close_op = 1'b1;
               end
            end else if (tecla_valida) begin
               cur_d  = shl_ext[W-1:0];
               wr_cur = 1'b1;
               if (num_q == LAST_DIG) begin
                  close_op = 1'b1;
               end else begin
                  num_d = num_q + 1'b1;
               end
            end
            if (wr_cur) begin
               ops_d[base +: W] = cur_d;
            end
            if (close_op) begin
               num_d = '0;
               if (op_idx_q == LAST_OP) begin
                  state_d = S_READY;
                  ready_d = 1'b1;
               end else begin
                  op_idx_d = op_idx_q + 1'b1;
               end
            end
         end
         S_READY: begin
            if (consumido) begin
               state_d  = S_CAPTURA;
               ops_d    = '0;
               op_idx_d = '0;
               num_d    = '0;
               ready_d  = 1'b0;
            end
         end
         default: begin
            state_d = S_CAPTURA;
         end
      endcase
   end

   // State and output registers; reset discards every operand.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_CAPTURA;
         ops_q    <= '0;
         op_idx_q <= '0;
         num_q    <= '0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         ops_q    <= ops_d;
         op_idx_q <= op_idx_d;
         num_q    <= num_d;
         ready_q  <= ready_d;
      end
   end

   assign operandos      = ops_q;
   assign op_idx         = op_idx_q;
   assign num_digitos    = num_q;
   assign ready_operands = ready_q;

endmodule

// File: doc/captura_operandos_n.md
CAPTURA_OPERANDOS_N -- requirements
Module: captura_operandos_n

Interface
REQ-001 SHALL provide parameter NUM_OPS, default 2, number of operands captured per sequence (legal range 2..8).
REQ-002 SHALL provide parameter DIGITS, default 2, maximum hex digits per operand (legal range 1..8); operand width W = 4*DIGITS.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port tecla  input  4  debounced hex key value, sampled only when a strobe is high.
REQ-006 SHALL have port tecla_valida  input  1  one-cycle strobe: tecla holds a digit.
REQ-007 SHALL have port tecla_borrar  input  1  one-cycle strobe: backspace.
REQ-008 SHALL have port tecla_enter  input  1  one-cycle strobe: close current operand early.
REQ-009 SHALL have port consumido  input  1  one-cycle strobe from consumer: operands taken, re-arm.
REQ-010 SHALL have port operandos  output  NUM_OPS*W  operand k in bits [k*W +: W], operand 0 in LSBs.
REQ-011 SHALL have port op_idx  output  clog2(NUM_OPS)  index of operand being entered.
REQ-012 SHALL have port num_digitos  output  clog2(DIGITS+1)  digits entered into current operand.
REQ-013 SHALL have port ready_operands  output  1  level: all operands complete and stable.

Function
REQ-014 SHALL implement two states, CAPTURA and READY; all outputs registered.
REQ-015 In CAPTURA, tecla_valida with num_digitos < DIGITS SHALL update current operand to (value<<4)|tecla truncated to W bits and increment num_digitos.
REQ-016 When a digit brings num_digitos to DIGITS, next cycle SHALL auto-advance: op_idx+1, num_digitos=0; on last operand, go to READY instead.
REQ-017 tecla_enter with num_digitos >= 1 SHALL close the operand as in REQ-016, value right-aligned with zero upper digits; with num_digitos = 0 SHALL be ignored.
REQ-018 tecla_borrar with num_digitos >= 1 SHALL shift current operand right 4 bits and decrement num_digitos; with num_digitos = 0 SHALL be ignored (no return to previous operand).
REQ-019 Simultaneous strobes SHALL resolve by priority rst > tecla_borrar > tecla_enter > tecla_valida; only the winner takes effect that cycle.
REQ-020 ready_operands SHALL be 1 exactly while in READY, asserted the cycle after the edge that completed the last operand.
REQ-021 In READY, tecla_valida, tecla_borrar and tecla_enter SHALL be ignored; operandos SHALL hold.
REQ-022 consumido in READY SHALL, next cycle, clear operandos, op_idx and num_digitos to 0 and return to CAPTURA; consumido in CAPTURA SHALL be ignored.
REQ-023 Completed operands SHALL never change while later operands are entered.
REQ-024 Auto-advance SHALL consume no extra key: the digit arriving the cycle after completion belongs to the next operand.

Reset
REQ-025 rst high at a clock edge SHALL set state CAPTURA, operandos=0, op_idx=0, num_digitos=0, ready_operands=0, overriding any strobe.
REQ-026 rst mid-entry or in READY SHALL discard all partial and completed operands.

Verification (NUM_OPS=2, DIGITS=2)
REQ-027 Keys 3,A,1,F -> operandos[7:0]=0x3A, [15:8]=0x1F, ready_operands=1 one cycle after the F strobe.
REQ-028 Keys 5, enter, 7, 2 -> operand0=0x05, operand1=0x72, ready; enter at num_digitos=0 before 5 has no effect.
REQ-029 Keys 3, A, borrar (before second digit completes? no: 3, borrar, C, A) -> operand0=0xCA; borrar at num_digitos=0 leaves op_idx=0.
REQ-030 Same cycle tecla_valida=1 (tecla=9) and tecla_borrar=1 after digit 4 -> operand0=0x0, num_digitos=0 (borrar wins, 9 dropped).
REQ-031 In READY, key 7 ignored; consumido -> next cycle ready_operands=0, operandos=0, op_idx=0.
REQ-032 rst after keys 3,A,1 -> all outputs 0; then 2,2,4,4 -> operands 0x22, 0x44, ready.
